// File: rtl/reg_file.sv
// Architectural register file: DATA_D x DATA_W words, one shared address,
// active-low synchronous write, combinational read, async active-low clear.
// Ports:
//   clk    - write clock (rising edge)
//   reset_ - async active-low reset, clears every word
//   addr   - word address shared by read and write
//   d_in   - write data
//   we_    - write enable, active low
//   d_out  - read data for ff[addr], 0 when addr is out of range
module reg_file #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DATA_D = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              we_,
  output logic [DATA_W-1:0] d_out
);

  logic [DATA_W-1:0] ff_q [DATA_D];
  logic [DATA_W-1:0] ff_d [DATA_D];

  logic in_range;
  logic wr_en;

  // Addresses past the last word neither write nor read back data.
  assign in_range = (32'(addr) < DATA_D);
  assign wr_en    = !we_ && in_range;

  always_comb begin
    ff_d = ff_q;
    if (wr_en) begin
      ff_d[addr] = d_in;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < int'(DATA_D); i++) begin
        ff_q[i] <= '0;
      end
    end else begin
      ff_q <= ff_d;
    end
  end

  // No write-through: d_out shows stored content only.
  always_comb begin
    d_out = '0;
    if (in_range) begin
      d_out = ff_q[addr];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic,
// expected read data queued from a behavioural array model.
module tb_reg_file;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DD = 32;

  logic          clk = 1'b0;
  logic          reset_;
  logic [AW-1:0] addr;
  logic [DW-1:0] d_in;
  logic          we_;
  logic [DW-1:0] d_out;

  reg_file #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DATA_D(DD)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .addr  (addr),
    .d_in  (d_in),
    .we_   (we_),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [DD];

  typedef struct {
    int unsigned   a;
    logic [DW-1:0] v;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  event smp;

  task automatic clear_model();
    for (int i = 0; i < DD; i++) model[i] = '0;
  endtask

  task automatic check(input string nm);
    exp_t e;
    #1;
    e.a    = int'(addr);
    e.v    = (e.a < DD) ? model[e.a] : '0;
    e.name = nm;
    exp_q.push_back(e);
    ->smp;
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(smp);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL monitor: sample with empty queue, got=%h", d_out);
      end else begin
        e = exp_q.pop_front();
        if (d_out !== e.v) begin
          failures++;
          $display("FAIL %s addr=%0d got=%h exp=%h",
                   e.name, e.a, d_out, e.v);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    addr = AW'(a);
    d_in = d;
    we_  = 1'b0;
    @(posedge clk);
    if (reset_ && a < DD) model[a] = d;
    #1;
    we_  = 1'b1;
    d_in = '0;
  endtask

  task automatic rd(input int a, input string nm);
    @(negedge clk);
    addr = AW'(a);
    check(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic [DW-1:0] d;
    reset_ = 1'b0;
    addr   = '0;
    d_in   = '0;
    we_    = 1'b1;
    clear_model();
    #2;
    check("reset_state");
    @(negedge clk);
    reset_ = 1'b1;

    for (int i = 0; i < 20; i++) wr(int'($urandom_range(0, DD-1)), $urandom());
    @(negedge clk);
    reset_ = 1'b0;
    clear_model();
    @(negedge clk);
    reset_ = 1'b1;
    for (int i = 0; i < DD; i++) rd(i, "reset_clear");

    for (int i = 0; i < DD; i++) begin
      wr(i, DW'(i));
      check("walk_wr");
    end
    for (int i = 0; i < DD; i++) rd(i, "walk_rd");

    @(negedge clk);
    addr = 5;
    d_in = 32'hDEADBEEF;
    we_  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      check("wr_dis");
    end

    wr(3, '0);
    @(negedge clk);
    addr = 3;
    d_in = 32'hA5A5A5A5;
    we_  = 1'b0;
    check("nobyp_pre");
    @(posedge clk);
    model[3] = 32'hA5A5A5A5;
    check("nobyp_post");
    we_  = 1'b1;
    d_in = '0;
    for (int i = 0; i < DD; i++) rd(i, "nobyp_all");

    for (int i = 0; i < DD; i++) wr(i, $urandom() | 32'h1);
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    clear_model();
    check("async_rst");
    @(negedge clk);
    we_  = 1'b0;
    d_in = 32'hCAFEF00D;
    addr = 7;
    @(posedge clk);
    #1;
    addr = 12;
    @(posedge clk);
    #1;
    check("rst_hold");
    we_ = 1'b1;
    @(negedge clk);
    reset_ = 1'b1;
    for (int i = 0; i < DD; i++) rd(i, "post_rst");

    wr(30, 32'h30303030);
    @(negedge clk);
    addr = 31;
    d_in = 32'h11111111;
    we_  = 1'b0;
    @(posedge clk);
    model[31] = 32'h11111111;
    @(negedge clk);
    d_in = 32'h22222222;
    @(posedge clk);
    model[31] = 32'h22222222;
    #1;
    we_  = 1'b1;
    d_in = '0;
    check("ovw31");
    rd(30, "ovw30");

    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, DD-1));
      d = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        wr(a, d);
        check("rand_wr");
      end else begin
        rd(a, "rand_rd");
      end
    end

    #20;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
